// File: rtl/main_mem_responder.sv
// Main memory responder: fixed-latency 512-bit line reads, 32-bit word writes.
// Optional bounds checking is compiled in with MAIN_MEM_BOUNDS_CHECK_EN.
module main_mem_responder #(
    parameter int LINE_DEPTH = 64,
    parameter int LATENCY    = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  main_mem_addr,
    input  logic [31:0]  main_mem_data_out,
    input  logic         main_mem_read_req,
    input  logic         main_mem_write_req,
    output logic [511:0] main_mem_data_in,
    output logic         main_mem_ready,
    output logic         main_mem_busy
`ifdef MAIN_MEM_BOUNDS_CHECK_EN
    ,
    output logic         main_mem_error
`endif
);

    localparam int IDX_W = $clog2(LINE_DEPTH);

`ifdef MAIN_MEM_BOUNDS_CHECK_EN
    // Full address is kept so out-of-range requests can be detected.
    localparam int AW = 32;
    localparam logic [32:0] SPAN = 33'(LINE_DEPTH) * 33'd64;
`else
    // Only the line index and word offset matter; upper bits wrap.
    localparam int AW = 6 + IDX_W;
`endif

    localparam logic [3:0] LAST = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ_WAIT,
        WRITE_WAIT,
        DONE
    } state_t;

    state_t            state;
    logic [3:0]        count;
    logic [AW-1:2]     addr_q;
    logic [31:0]       wdata_q;
    logic [511:0]      mem [LINE_DEPTH];

    logic [IDX_W-1:0]  line_idx;
    logic [3:0]        word_idx;
    logic              wait_done;
    logic              in_range;
    logic              commit_write;
    logic              unused_addr;

    assign line_idx  = addr_q[6 +: IDX_W];
    assign word_idx  = addr_q[5:2];
    assign wait_done = (count == LAST);

`ifdef MAIN_MEM_BOUNDS_CHECK_EN
    assign in_range    = ({1'b0, addr_q, 2'b00} < SPAN);
    assign unused_addr = ^main_mem_addr[1:0];
`else
    assign in_range    = 1'b1;
    assign unused_addr = ^{main_mem_addr[31:AW],
                           main_mem_addr[1:0]};
`endif

    // The write lands on the same edge the FSM enters DONE; reset aborts it.
    assign commit_write = (state == WRITE_WAIT) && wait_done
                          && !rst && in_range;

    // Request capture, latency count and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            count            <= '0;
            addr_q           <= '0;
            wdata_q          <= '0;
            main_mem_ready   <= 1'b0;
            main_mem_busy    <= 1'b0;
            main_mem_data_in <= '0;
`ifdef MAIN_MEM_BOUNDS_CHECK_EN
            main_mem_error   <= 1'b0;
`endif
        end else begin
            main_mem_ready <= 1'b0;
`ifdef MAIN_MEM_BOUNDS_CHECK_EN
            main_mem_error <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    // Read has priority; a simultaneous write is dropped.
                    if (main_mem_read_req) begin
                        addr_q        <= main_mem_addr[AW-1:2];
                        count         <= '0;
                        state         <= READ_WAIT;
                        main_mem_busy <= 1'b1;
                    end else if (main_mem_write_req) begin
                        addr_q        <= main_mem_addr[AW-1:2];
                        wdata_q       <= main_mem_data_out;
                        count         <= '0;
                        state         <= WRITE_WAIT;
                        main_mem_busy <= 1'b1;
                    end
                end
                READ_WAIT: begin
                    count <= count + 4'd1;
                    if (wait_done) begin
                        state          <= DONE;
                        main_mem_ready <= 1'b1;
                        main_mem_data_in <= in_range ? mem[line_idx]
                                                     : '0;
`ifdef MAIN_MEM_BOUNDS_CHECK_EN
                        main_mem_error <= !in_range;
`endif
                    end
                end
                WRITE_WAIT: begin
                    count <= count + 4'd1;
                    if (wait_done) begin
                        state          <= DONE;
                        main_mem_ready <= 1'b1;
`ifdef MAIN_MEM_BOUNDS_CHECK_EN
                        main_mem_error <= !in_range;
`endif
                    end
                end
                DONE: begin
                    // Requests are not looked at here, only in IDLE.
                    state         <= IDLE;
                    count         <= '0;
                    main_mem_busy <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Backing store: single word update, never cleared by reset.
    always_ff @(posedge clk) begin
        if (commit_write) begin
            mem[line_idx][{word_idx, 5'b0} +: 32] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed bench for main_mem_responder (default parameters).
// Builds with or without MAIN_MEM_BOUNDS_CHECK_EN.
module tb_main_mem_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic         rd;
    logic         wr;
    logic [511:0] data_in;
    logic         ready;
    logic         busy;
`ifdef MAIN_MEM_BOUNDS_CHECK_EN
    logic         error;
`endif

    int errors = 0;
    int checks = 0;
    logic err_seen;
    logic [511:0] exp_line;

    localparam int EXP_LAT = 5;

    main_mem_responder dut (
        .clk                (clk),
        .rst                (rst),
        .main_mem_addr      (addr),
        .main_mem_data_out  (wdata),
        .main_mem_read_req  (rd),
        .main_mem_write_req (wr),
        .main_mem_data_in   (data_in),
        .main_mem_ready     (ready),
        .main_mem_busy      (busy)
`ifdef MAIN_MEM_BOUNDS_CHECK_EN
        ,
        .main_mem_error     (error)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input logic [511:0] obs,
                       input logic [511:0] exp,
                       input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    // All steps start and end 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic r, input logic w,
                         input logic [31:0] a,
                         input logic [31:0] d);
        rd = r;
        wr = w;
        addr = a;
        wdata = d;
        step();
        rd = 1'b0;
        wr = 1'b0;
    endtask

    // Latency = number of edges after capture until the edge
    // that samples ready high.
    task automatic wait_ready(input string tag);
        int lat;
        lat = 0;
        err_seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (ready === 1'b1) begin
                lat = k + 1;
`ifdef MAIN_MEM_BOUNDS_CHECK_EN
                err_seen = error;
`endif
                break;
            end
            step();
        end
        chk(512'(lat), 512'(EXP_LAT), {tag, "_latency"});
        step();
        chk(512'(ready), 512'(0), {tag, "_ready_pulse"});
        chk(512'(busy), 512'(0), {tag, "_busy_idle"});
    endtask

    task automatic op(input logic r, input logic w,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      input string tag);
        issue(r, w, a, d);
        chk(512'(busy), 512'(1), {tag, "_busy"});
        wait_ready(tag);
    endtask

    initial begin
        int pulses;
        logic [31:0] a_w;
        logic [31:0] a_r;

        rst = 1'b1;
        rd = 1'b0;
        wr = 1'b0;
        addr = '0;
        wdata = '0;
        repeat (3) step();
        chk(512'(ready), 512'(0), "reset_ready");
        chk(512'(busy), 512'(0), "reset_busy");
        chk(data_in, 512'(0), "reset_data");
        rst = 1'b0;
        step();

        // Write-then-read in line 0, word 2.
`ifdef MAIN_MEM_BOUNDS_CHECK_EN
        a_w = 32'h0008;
        a_r = 32'h0000;
`else
        a_w = 32'h2008;
        a_r = 32'h2000;
`endif
        op(1'b0, 1'b1, a_w, 32'hDEADBEEF, "wr_2008");
        op(1'b1, 1'b0, a_r, 32'h0, "rd_2000");
        chk(512'(data_in[95:64]), 512'(32'hDEADBEEF),
            "rd_2000_word2");

        // Full line of line 0.
        for (int k = 0; k < 16; k++) begin
            op(1'b0, 1'b1, 32'(4 * k), 32'h1000 + 32'(4 * k),
               "wr_line0");
            exp_line[32 * k +: 32] = 32'h1000 + 32'(4 * k);
        end
        op(1'b1, 1'b0, 32'h0020, 32'h0, "rd_line0");
        chk(data_in, exp_line, "rd_line0_data");

        // A write must not disturb the last read line.
        op(1'b0, 1'b1, 32'h0080, 32'h5555_5555, "wr_0080");
        chk(data_in, exp_line, "data_hold_after_wr");

        // Seed line 1; byte offset in addr[1:0] is ignored.
        op(1'b0, 1'b1, 32'h0040, 32'h1111_1111, "wr_0040");
        op(1'b0, 1'b1, 32'h0047, 32'h2222_2222, "wr_0047");

        // Read wins over a simultaneous write.
        op(1'b1, 1'b1, 32'h0040, 32'hBAD0_BAD0, "rdwr_0040");
        chk(512'(data_in[63:0]), 512'(64'h2222_2222_1111_1111),
            "rdwr_0040_data");
        op(1'b1, 1'b0, 32'h0040, 32'h0, "rd_0040");
        chk(512'(data_in[63:0]), 512'(64'h2222_2222_1111_1111),
            "rd_0040_unchanged");

        // Write request while busy with a read is ignored.
        issue(1'b1, 1'b0, 32'h0040, 32'h0);
        step();
        wr = 1'b1;
        addr = 32'h0040;
        wdata = 32'h9999_9999;
        step();
        wr = 1'b0;
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            if (ready === 1'b1) pulses++;
            step();
        end
        chk(512'(pulses), 512'(1), "busy_ignore_pulses");
        op(1'b1, 1'b0, 32'h0040, 32'h0, "rd_after_ignore");
        chk(512'(data_in[31:0]), 512'(32'h1111_1111),
            "busy_ignore_mem");

        // Reset in WRITE_WAIT drops the write.
        issue(1'b0, 1'b1, 32'h0040, 32'h7777_7777);
        step();
        rst = 1'b1;
        step();
        chk(512'(ready), 512'(0), "midrst_ready");
        chk(512'(busy), 512'(0), "midrst_busy");
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            if (ready === 1'b1) pulses++;
            step();
        end
        chk(512'(pulses), 512'(0), "midrst_no_pulse");
        op(1'b1, 1'b0, 32'h0040, 32'h0, "rd_after_rst");
        chk(512'(data_in[31:0]), 512'(32'h1111_1111),
            "midrst_old_word");

        // Address beyond LINE_DEPTH*64 bytes.
        op(1'b1, 1'b0, 32'h1000, 32'h0, "rd_1000");
`ifdef MAIN_MEM_BOUNDS_CHECK_EN
        chk(512'(err_seen), 512'(1), "oob_error");
        chk(data_in, 512'(0), "oob_zero_line");
`else
        chk(data_in, exp_line, "wrap_line0");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
